// File: rtl/fetch_unit.sv
// DLX instruction-fetch stage: owns the PC and the I-mem request handshake,
// resolves control transfers into fetch redirects, and holds the IF/ID register.
module fetch_unit #(
    parameter logic [0:31] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [0:31] IMemAddr,
    input  logic        IMemValid,
    input  logic [0:31] IMemData,
    input  logic        Stall,
    input  logic        ResolveValid,
    input  logic        ResolveIsJump,
    input  logic        ResolveIsBranch,
    input  logic [0:1]  ResolveJumpType,
    input  logic        ResolveCondSrc,
    input  logic        ResolveBranchCond,
    input  logic [0:31] ResolvePCPlus4,
    input  logic [0:25] ResolveImm,
    input  logic [0:31] RegA,
    input  logic        CondZero,
    input  logic        FPSR,
    input  logic [0:31] IAR,
    output logic        IFID_Valid,
    output logic [0:31] IFID_Instr,
    output logic [0:31] IFID_PCPlus4,
    output logic [0:5]  OpCode,
    output logic [0:5]  Function,
    output logic        Redirect,
    output logic [0:31] RedirectTarget
);

    typedef enum logic [1:0] {StStart, StFetch, StDiscard, StHold} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [0:31] r_req_addr;
    logic [0:31] r_pend_tgt;
    logic [0:31] r_skid;
    logic        r_ifid_valid;
    logic [0:31] r_ifid_instr;
    logic [0:31] r_ifid_pcplus4;

    logic [0:31] w_req_addr_d;
    logic [0:31] w_pend_tgt_d;
    logic [0:31] w_skid_d;
    logic        w_ifid_valid_d;
    logic [0:31] w_ifid_instr_d;
    logic [0:31] w_ifid_pcplus4_d;
    logic        w_taken;
    logic [0:31] w_imm16_sext;
    logic [0:31] w_imm26_sext;

    assign w_taken      = (ResolveCondSrc ? CondZero : FPSR) == ResolveBranchCond;
    assign Redirect     = ResolveValid & (ResolveIsJump | (ResolveIsBranch & w_taken));
    assign w_imm16_sext = {{16{ResolveImm[10]}}, ResolveImm[10:25]};
    assign w_imm26_sext = {{6{ResolveImm[0]}}, ResolveImm};

    always_comb begin
        RedirectTarget = RegA;
        unique case (ResolveJumpType)
            2'b00: RedirectTarget = RegA;
            2'b01: RedirectTarget = ResolvePCPlus4 + w_imm16_sext;
            2'b10: RedirectTarget = ResolvePCPlus4 + w_imm26_sext;
            2'b11: RedirectTarget = IAR;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= StStart;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StStart: w_state_next = StFetch;
            StFetch: begin
                if (IMemValid && !Redirect && Stall) begin
                    w_state_next = StHold;
                end else if (!IMemValid && Redirect) begin
                    w_state_next = StDiscard;
                end
            end
            StDiscard: begin
                if (IMemValid) begin
                    w_state_next = StFetch;
                end
            end
            StHold: begin
                if (Redirect || !Stall) begin
                    w_state_next = StFetch;
                end
            end
        endcase
    end

    always_comb begin
        IMemReq = 1'b0;
        unique case (r_state)
            StFetch, StDiscard: IMemReq = 1'b1;
            default:            IMemReq = 1'b0;
        endcase
    end

    always_comb begin
        w_req_addr_d     = r_req_addr;
        w_pend_tgt_d     = r_pend_tgt;
        w_skid_d         = r_skid;
        w_ifid_valid_d   = r_ifid_valid;
        w_ifid_instr_d   = r_ifid_instr;
        w_ifid_pcplus4_d = r_ifid_pcplus4;
        unique case (r_state)
            StStart: begin
            end
            StFetch: begin
                if (IMemValid) begin
                    if (Redirect) begin
                        w_req_addr_d = RedirectTarget;
                    end else begin
                        w_req_addr_d = r_req_addr + 32'd4;
                        if (Stall) begin
                            w_skid_d = IMemData;
                        end else begin
                            w_ifid_valid_d   = 1'b1;
                            w_ifid_instr_d   = IMemData;
                            w_ifid_pcplus4_d = r_req_addr + 32'd4;
                        end
                    end
                end else if (Redirect) begin
                    w_pend_tgt_d = RedirectTarget;
                end else if (!Stall) begin
                    w_ifid_valid_d = 1'b0;
                    w_ifid_instr_d = 32'h0;
                end
            end
            StDiscard: begin
                // The in-flight response belongs to the old path; the newest target wins.
                if (Redirect) begin
                    w_pend_tgt_d = RedirectTarget;
                end
                if (IMemValid) begin
                    w_req_addr_d = Redirect ? RedirectTarget : r_pend_tgt;
                end
                if (!Stall) begin
                    w_ifid_valid_d = 1'b0;
                    w_ifid_instr_d = 32'h0;
                end
            end
            StHold: begin
                if (Redirect) begin
                    w_req_addr_d = RedirectTarget;
                    w_skid_d     = 32'h0;
                end else if (!Stall) begin
                    // ReqAddr already advanced past the skid word, so it is the skid's PC+4.
                    w_ifid_valid_d   = 1'b1;
                    w_ifid_instr_d   = r_skid;
                    w_ifid_pcplus4_d = r_req_addr;
                end
            end
        endcase
        if (Redirect) begin
            w_ifid_valid_d = 1'b0;
            w_ifid_instr_d = 32'h0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_req_addr     <= RESET_PC;
            r_pend_tgt     <= RESET_PC;
            r_skid         <= 32'h0;
            r_ifid_valid   <= 1'b0;
            r_ifid_instr   <= 32'h0;
            r_ifid_pcplus4 <= 32'h0;
        end else begin
            r_req_addr     <= w_req_addr_d;
            r_pend_tgt     <= w_pend_tgt_d;
            r_skid         <= w_skid_d;
            r_ifid_valid   <= w_ifid_valid_d;
            r_ifid_instr   <= w_ifid_instr_d;
            r_ifid_pcplus4 <= w_ifid_pcplus4_d;
        end
    end

    assign IMemAddr     = r_req_addr;
    assign IFID_Valid   = r_ifid_valid;
    assign IFID_Instr   = r_ifid_instr;
    assign IFID_PCPlus4 = r_ifid_pcplus4;
    assign OpCode       = r_ifid_instr[0:5];
    assign Function     = r_ifid_instr[26:31];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/skid, branch and jump
// redirects, discard of in-flight responses, and asynchronous reset.
module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        IMemReq;
    logic [0:31] IMemAddr;
    logic        IMemValid;
    logic [0:31] IMemData;
    logic        Stall;
    logic        ResolveValid;
    logic        ResolveIsJump;
    logic        ResolveIsBranch;
    logic [0:1]  ResolveJumpType;
    logic        ResolveCondSrc;
    logic        ResolveBranchCond;
    logic [0:31] ResolvePCPlus4;
    logic [0:25] ResolveImm;
    logic [0:31] RegA;
    logic        CondZero;
    logic        FPSR;
    logic [0:31] IAR;
    logic        IFID_Valid;
    logic [0:31] IFID_Instr;
    logic [0:31] IFID_PCPlus4;
    logic [0:5]  OpCode;
    logic [0:5]  Function;
    logic        Redirect;
    logic [0:31] RedirectTarget;

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc4[$];

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .IMemReq          (IMemReq),
        .IMemAddr         (IMemAddr),
        .IMemValid        (IMemValid),
        .IMemData         (IMemData),
        .Stall            (Stall),
        .ResolveValid     (ResolveValid),
        .ResolveIsJump    (ResolveIsJump),
        .ResolveIsBranch  (ResolveIsBranch),
        .ResolveJumpType  (ResolveJumpType),
        .ResolveCondSrc   (ResolveCondSrc),
        .ResolveBranchCond(ResolveBranchCond),
        .ResolvePCPlus4   (ResolvePCPlus4),
        .ResolveImm       (ResolveImm),
        .RegA             (RegA),
        .CondZero         (CondZero),
        .FPSR             (FPSR),
        .IAR              (IAR),
        .IFID_Valid       (IFID_Valid),
        .IFID_Instr       (IFID_Instr),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .OpCode           (OpCode),
        .Function         (Function),
        .Redirect         (Redirect),
        .RedirectTarget   (RedirectTarget)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h2001_0004;
        if (a == 32'h104) return 32'h2002_0008;
        return {16'h2003, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge Clk);
        #1;
        IMemValid = 1'b0;
        IMemData  = 32'h0;
    endtask

    task automatic clr_resolve();
        ResolveValid      = 1'b0;
        ResolveIsJump     = 1'b0;
        ResolveIsBranch   = 1'b0;
        ResolveJumpType   = 2'b00;
        ResolveCondSrc    = 1'b0;
        ResolveBranchCond = 1'b0;
        ResolvePCPlus4    = 32'h0;
        ResolveImm        = 26'h0;
        RegA              = 32'h0;
        CondZero          = 1'b0;
        FPSR              = 1'b0;
        IAR               = 32'h0;
    endtask

    // Memory answers the current request; accepted words are queued for IF/ID.
    task automatic respond(input bit accept);
        IMemValid = 1'b1;
        IMemData  = mem_word(IMemAddr);
        if (accept) begin
            q_instr.push_back(mem_word(IMemAddr));
            q_pc4.push_back(IMemAddr + 32'd4);
        end
    endtask

    task automatic pop_chk(input string tag);
        if (q_instr.size() == 0) begin
            chk({tag, "_sb"}, 32'(q_instr.size()), 32'd1);
        end else begin
            chk({tag, "_valid"}, IFID_Valid, 32'd1);
            chk({tag, "_instr"}, IFID_Instr, q_instr.pop_front());
            chk({tag, "_pc4"}, IFID_PCPlus4, q_pc4.pop_front());
        end
    endtask

    task automatic beqz(input logic cz);
        ResolveValid      = 1'b1;
        ResolveIsBranch   = 1'b1;
        ResolveJumpType   = 2'b01;
        ResolveCondSrc    = 1'b1;
        ResolveBranchCond = 1'b1;
        CondZero          = cz;
        ResolvePCPlus4    = 32'h200;
        ResolveImm        = 26'h000_FFF0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, IMemReq, 32'd0);
        chk({tag, "_addr"}, IMemAddr, 32'h100);
        chk({tag, "_valid"}, IFID_Valid, 32'd0);
        chk({tag, "_instr"}, IFID_Instr, 32'h0);
        chk({tag, "_pc4"}, IFID_PCPlus4, 32'h0);
    endtask

    initial begin
        Reset     = 1'b1;
        Stall     = 1'b0;
        IMemValid = 1'b0;
        IMemData  = 32'h0;
        clr_resolve();
        @(posedge Clk);
        #1;
        check_reset_vals("rst");
        Reset = 1'b0;
        chk("start_req", IMemReq, 32'd0);

        // Sequential fetch with single-cycle memory
        next();
        chk("t1_req", IMemReq, 32'd1);
        chk("t1_addr0", IMemAddr, 32'h100);
        respond(1'b1);
        next();
        pop_chk("t1_w0");
        chk("t1_opcode", OpCode, 32'h08);
        chk("t1_addr1", IMemAddr, 32'h104);
        respond(1'b1);
        next();
        pop_chk("t1_w1");
        chk("t1_func", Function, 32'h08);
        chk("t1_addr2", IMemAddr, 32'h108);
        respond(1'b1);
        next();
        pop_chk("t1_w2");
        chk("t1_addr3", IMemAddr, 32'h10C);

        // Stall high for three cycles starting with a response
        Stall = 1'b1;
        respond(1'b1);
        for (int i = 0; i < 3; i++) begin
            next();
            chk("t2_req_low", IMemReq, 32'd0);
            chk("t2_hold_instr", IFID_Instr, 32'h2003_0108);
            chk("t2_hold_pc4", IFID_PCPlus4, 32'h10C);
            if (i == 2) Stall = 1'b0;
        end
        next();
        pop_chk("t2_skid");
        chk("t2_req", IMemReq, 32'd1);
        chk("t2_addr", IMemAddr, 32'h110);
        respond(1'b1);
        next();
        pop_chk("t2_next");
        chk("t2_addr2", IMemAddr, 32'h114);

        // Taken BEQZ with a response in the same cycle
        beqz(1'b1);
        respond(1'b0);
        #1;
        chk("t3_redirect", Redirect, 32'd1);
        chk("t3_target", RedirectTarget, 32'h1F0);
        next();
        clr_resolve();
        chk("t3_flush_valid", IFID_Valid, 32'd0);
        chk("t3_flush_instr", IFID_Instr, 32'h0);
        chk("t3_addr", IMemAddr, 32'h1F0);
        respond(1'b1);
        next();
        pop_chk("t3_tgt_word");
        chk("t3_addr2", IMemAddr, 32'h1F4);

        // Not-taken BEQZ, then an FPSR-sourced branch with a 26-bit negative offset
        beqz(1'b0);
        respond(1'b1);
        #1;
        chk("t4_redirect", Redirect, 32'd0);
        next();
        clr_resolve();
        pop_chk("t4_seq");
        chk("t4_addr", IMemAddr, 32'h1F8);
        ResolveValid      = 1'b1;
        ResolveIsBranch   = 1'b1;
        ResolveJumpType   = 2'b10;
        ResolveCondSrc    = 1'b0;
        ResolveBranchCond = 1'b0;
        FPSR              = 1'b1;
        ResolvePCPlus4    = 32'h1000;
        ResolveImm        = 26'h3FF_FFFC;
        respond(1'b1);
        #1;
        chk("t4_fpsr_nt", Redirect, 32'd0);
        chk("t4_imm26_tgt", RedirectTarget, 32'hFFC);
        FPSR = 1'b0;
        #1;
        chk("t4_fpsr_tk", Redirect, 32'd1);
        FPSR = 1'b1;
        next();
        clr_resolve();
        pop_chk("t4_fpsr_seq");
        chk("t4_addr2", IMemAddr, 32'h1FC);

        // Slow memory: redirects while the request is outstanding
        next();
        chk("t5_bubble_valid", IFID_Valid, 32'd0);
        chk("t5_bubble_instr", IFID_Instr, 32'h0);
        ResolveValid  = 1'b1;
        ResolveIsJump = 1'b1;
        RegA          = 32'h400;
        #1;
        chk("t5_jr_redirect", Redirect, 32'd1);
        chk("t5_jr_target", RedirectTarget, 32'h400);
        next();
        clr_resolve();
        chk("t5_disc_req", IMemReq, 32'd1);
        chk("t5_disc_addr0", IMemAddr, 32'h1FC);
        next();
        chk("t5_disc_addr1", IMemAddr, 32'h1FC);
        ResolveValid    = 1'b1;
        ResolveIsJump   = 1'b1;
        ResolveJumpType = 2'b11;
        IAR             = 32'h800;
        #1;
        chk("t5_iar_target", RedirectTarget, 32'h800);
        next();
        clr_resolve();
        chk("t5_disc_addr2", IMemAddr, 32'h1FC);
        respond(1'b0);
        next();
        chk("t5_iar_addr", IMemAddr, 32'h800);
        chk("t5_iar_valid", IFID_Valid, 32'd0);
        ResolveValid  = 1'b1;
        ResolveIsJump = 1'b1;
        RegA          = 32'h400;
        next();
        clr_resolve();
        chk("t5_disc2_addr", IMemAddr, 32'h800);
        respond(1'b0);
        next();
        chk("t5_jr_addr", IMemAddr, 32'h400);
        respond(1'b1);
        next();
        pop_chk("t5_jr_word");
        chk("t5_addr_after", IMemAddr, 32'h404);

        // Asynchronous reset in the middle of a fetch cycle
        #2;
        Reset = 1'b1;
        #1;
        check_reset_vals("t6_async");
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("t6_start_req", IMemReq, 32'd0);
        next();
        chk("t6_req", IMemReq, 32'd1);
        chk("t6_addr", IMemAddr, 32'h100);
        respond(1'b1);
        next();
        pop_chk("t6_first");
        chk("sb_empty", 32'(q_instr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the pipelined DLX core.
- Owns the PC and the instruction-memory request handshake, and holds the fetched word in IF/ID.
- Drives the OpCode/Function fields consumed by the control decoder.
- Consumes the decoder's IFetch controls (JumpType, CondSrc, BranchCond), resolved downstream, to redirect fetch.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
Clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
IMemReq  out  1  request valid; held high with IMemAddr stable until IMemValid.
IMemAddr  out  [0:31]  fetch word address.
IMemValid  in  1  response strobe; completes the outstanding request.
IMemData  in  [0:31]  instruction word, valid with IMemValid.
Stall  in  1  hazard stall; IF/ID must hold.
ResolveValid  in  1  a control-transfer instruction is resolving this cycle.
ResolveIsJump  in  1  unconditional transfer.
ResolveIsBranch  in  1  conditional branch.
ResolveJumpType  in  [0:1]  00 RegA, 01 Imm16, 10 Imm26, 11 IAR.
ResolveCondSrc  in  1  1 = CondZero, 0 = FPSR.
ResolveBranchCond  in  1  taken polarity.
ResolvePCPlus4  in  [0:31]  PC+4 of the resolving instruction.
ResolveImm  in  [0:25]  instruction bits 6..31.
RegA  in  [0:31]  jump-register target.
CondZero  in  1  tested register == 0.
FPSR  in  1  FP status bit.
IAR  in  [0:31]  interrupt return address.
IFID_Valid  out  1  IF/ID holds a real instruction.
IFID_Instr  out  [0:31]  instruction word; 0 when invalid.
IFID_PCPlus4  out  [0:31]  fetch address + 4.
OpCode  out  [0:5]  IFID_Instr[0:5].
Function  out  [0:5]  IFID_Instr[26:31].
Redirect  out  1  combinational; taken transfer this cycle.
RedirectTarget  out  [0:31]  combinational target.

Behaviour:
- Reset (async): state START, ReqAddr=RESET_PC, IMemReq=0, IFID_Valid=0, IFID_Instr=0, IFID_PCPlus4=0, skid buffer empty.
- Taken condition: taken = (ResolveCondSrc ? CondZero : FPSR) == ResolveBranchCond.
- Redirect = ResolveValid & (ResolveIsJump | (ResolveIsBranch & taken)).
- Target by ResolveJumpType:
  - 00: RegA.
  - 01: ResolvePCPlus4 + sext(ResolveImm[10:25]).
  - 10: ResolvePCPlus4 + sext(ResolveImm[0:25]).
  - 11: IAR.
  - All adds are mod 2^32.
- Priority: Reset > Redirect > Stall > normal.
- Redirect flushes IF/ID (Valid=0, Instr=0) even if Stall=1.
- IMemAddr = ReqAddr register in all states.
- States:
  - START: IMemReq=0; next cycle goes to FETCH.
  - FETCH: IMemReq=1.
    - IMemValid & Redirect: drop the response; ReqAddr<=target; stay in FETCH.
    - IMemValid & !Stall: IF/ID<= {1, IMemData, ReqAddr+4}; ReqAddr+=4.
    - IMemValid & Stall: skid<=IMemData; ReqAddr+=4; go to HOLD.
    - !IMemValid & Redirect: PendTgt<=target; go to DISCARD.
    - !IMemValid & !Stall: IF/ID gets a bubble (Valid=0).
  - DISCARD: IMemReq=1, with the old ReqAddr held.
    - Redirect updates PendTgt; the latest redirect wins.
    - On IMemValid: drop the response; ReqAddr<=PendTgt; go to FETCH.
    - IF/ID receives bubbles unless Stall=1.
  - HOLD: IMemReq=0; IF/ID holds.
    - Redirect: drop skid; ReqAddr<=target; go to FETCH.
    - !Stall: IF/ID<= {1, skid, (ReqAddr-4)+4}; go to FETCH.
- Stall with no response pending: IF/ID holds and no response is lost.
- Latency: IMemValid in cycle N -> IFID_Valid visible in cycle N+1, and the next request is issued in cycle N+1.
- With single-cycle memory, throughput is 1 instruction/cycle.
- Invalid IF/ID decodes as opcode 00/function 00; writes to r0 are harmless.
- Reset mid-request abandons the request. Memory must tolerate IMemReq dropping.

Test Plan:
1. Reset, RESET_PC=0x100, memory always valid with words 0x20010004, 0x20020008 -> IMemAddr 0x100, 0x104, 0x108 on consecutive cycles; IFID_Instr appears one cycle after each response; OpCode=0x08 (ADDI); IFID_PCPlus4=0x104.
2. Stall held 3 cycles during a response -> IMemReq=0 for 3 cycles; IF/ID unchanged; the skid word enters IF/ID when Stall drops; no word is lost or duplicated.
3. BEQZ resolves with CondSrc=1, BranchCond=1, CondZero=1, JumpType=01, ResolvePCPlus4=0x200, imm16=0xFFF0 -> Redirect=1, target 0x1F0, IF/ID flushed, next IMemAddr=0x1F0.
4. Same branch with CondZero=0 -> Redirect=0 and sequential fetch continues.
5. Memory latency 4 cycles; a JR with RegA=0x400 arrives in cycle 1 of the wait -> enter DISCARD; IMemAddr holds until the response, which is dropped; then IMemAddr=0x400.
   - A second redirect to IAR=0x800 during DISCARD -> fetch goes to 0x800 instead.
6. Async Reset asserted mid-FETCH -> all outputs take reset values immediately; after release there is one START cycle, then IMemAddr=RESET_PC.
